// File: rtl/food_spawner.sv
// Food spawner: turns the free-running random stream into a legal, unoccupied
// food cell. Rejection-samples random candidates against the occupancy memory
// (1-cycle read latency) and falls back to a wrap-around scan after MAX_TRIES
// rejections. Flags board_full when every cell is occupied.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   req                      spawn request, sampled only in IDLE
//   rnd                      random value, decoded combinationally in SAMPLE
//   occ_rd_en/_x/_y          occupancy read port (decoded from state, not registered)
//   occ_rd_data              occupancy bit, valid the cycle after occ_rd_en
//   busy                     high whenever not IDLE
//   done                     1-cycle pulse when a spawn finishes
//   board_full               valid with done: no free cell, food unchanged
//   food_x, food_y           last accepted food cell
module food_spawner #(
  parameter int unsigned RND_W     = 9,
  parameter int unsigned GRID_W    = 16,
  parameter int unsigned GRID_H    = 16,
  parameter int unsigned X_W       = 4,
  parameter int unsigned Y_W       = 4,
  parameter int unsigned MAX_TRIES = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic [RND_W-1:0] rnd,
  output logic             occ_rd_en,
  output logic [X_W-1:0]   occ_rd_x,
  output logic [Y_W-1:0]   occ_rd_y,
  input  logic             occ_rd_data,
  output logic             busy,
  output logic             done,
  output logic             board_full,
  output logic [X_W-1:0]   food_x,
  output logic [Y_W-1:0]   food_y
);

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned CELLS = GRID_W * GRID_H;
  localparam int unsigned CNT_W = $clog2(CELLS + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAMPLE   = 3'd1,
    CHECK    = 3'd2,
    SCAN_RD  = 3'd3,
    SCAN_CHK = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [TRY_W-1:0] tries, tries_nxt, tries_inc;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [X_W-1:0]   cand_x, cand_x_nxt, ptr_x, ptr_x_nxt, food_x_nxt;
  logic [Y_W-1:0]   cand_y, cand_y_nxt, ptr_y, ptr_y_nxt, food_y_nxt;
  logic             done_nxt, full_nxt;
  logic [X_W-1:0]   cx;
  logic [Y_W-1:0]   cy;
  logic             in_range, tries_max, cnt_max;
  logic             rnd_unused;

  // Candidate fields; bits above X_W+Y_W are deliberately ignored.
  assign cx         = rnd[X_W-1:0];
  assign cy         = rnd[X_W+Y_W-1:X_W];
  assign rnd_unused = ^rnd;
  assign in_range   = (32'(cx) < GRID_W) && (32'(cy) < GRID_H);
  assign tries_inc  = tries + TRY_W'(1);
  assign tries_max  = (32'(tries_inc) == MAX_TRIES);
  assign cnt_inc    = cnt + CNT_W'(1);
  assign cnt_max    = (32'(cnt_inc) == CELLS);

  // Row-major successor cell, x fastest, wrapping at both grid edges.
  function automatic logic [X_W+Y_W-1:0] next_cell(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;
    nx = x + X_W'(1);
    ny = y;
    if (32'(x) == GRID_W - 1) begin
      nx = '0;
      ny = (32'(y) == GRID_H - 1) ? '0 : y + Y_W'(1);
    end
    return {ny, nx};
  endfunction

  // Next-state and registered-output decode.
  always_comb begin
    state_nxt  = state;
    tries_nxt  = tries;
    cnt_nxt    = cnt;
    cand_x_nxt = cand_x;
    cand_y_nxt = cand_y;
    ptr_x_nxt  = ptr_x;
    ptr_y_nxt  = ptr_y;
    food_x_nxt = food_x;
    food_y_nxt = food_y;
    done_nxt   = 1'b0;
    full_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = SAMPLE;
          tries_nxt = '0;
        end
      end
      SAMPLE: begin
        if (!in_range) begin
          tries_nxt = tries_inc;
          if (tries_max) begin
            // No in-range candidate to continue from: scan from the origin.
            state_nxt = SCAN_RD;
            ptr_x_nxt = '0;
            ptr_y_nxt = '0;
            cnt_nxt   = '0;
          end
        end else begin
          cand_x_nxt = cx;
          cand_y_nxt = cy;
          state_nxt  = CHECK;
        end
      end
      CHECK: begin
        if (!occ_rd_data) begin
          food_x_nxt = cand_x;
          food_y_nxt = cand_y;
          done_nxt   = 1'b1;
          state_nxt  = IDLE;
        end else begin
          tries_nxt = tries_inc;
          if (tries_max) begin
            state_nxt              = SCAN_RD;
            {ptr_y_nxt, ptr_x_nxt} = next_cell(cand_x, cand_y);
            cnt_nxt                = '0;
          end else begin
            state_nxt = SAMPLE;
          end
        end
      end
      SCAN_RD: begin
        state_nxt = SCAN_CHK;
      end
      SCAN_CHK: begin
        if (!occ_rd_data) begin
          food_x_nxt = ptr_x;
          food_y_nxt = ptr_y;
          done_nxt   = 1'b1;
          state_nxt  = IDLE;
        end else begin
          {ptr_y_nxt, ptr_x_nxt} = next_cell(ptr_x, ptr_y);
          cnt_nxt                = cnt_inc;
          if (cnt_max) begin
            done_nxt  = 1'b1;
            full_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = SCAN_RD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tries      <= '0;
      cnt        <= '0;
      cand_x     <= '0;
      cand_y     <= '0;
      ptr_x      <= '0;
      ptr_y      <= '0;
      food_x     <= '0;
      food_y     <= '0;
      done       <= 1'b0;
      board_full <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      tries      <= tries_nxt;
      cnt        <= cnt_nxt;
      cand_x     <= cand_x_nxt;
      cand_y     <= cand_y_nxt;
      ptr_x      <= ptr_x_nxt;
      ptr_y      <= ptr_y_nxt;
      food_x     <= food_x_nxt;
      food_y     <= food_y_nxt;
      done       <= done_nxt;
      board_full <= full_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

  // Occupancy read port, decoded so the read lands in the same cycle as the decision.
  always_comb begin
    occ_rd_en = 1'b0;
    occ_rd_x  = '0;
    occ_rd_y  = '0;
    if (state == SAMPLE && in_range) begin
      occ_rd_en = 1'b1;
      occ_rd_x  = cx;
      occ_rd_y  = cy;
    end else if (state == SCAN_RD) begin
      occ_rd_en = 1'b1;
      occ_rd_x  = ptr_x;
      occ_rd_y  = ptr_y;
    end
  end

endmodule

// File: tb/tb_food_spawner.sv
// Directed testbench for food_spawner: a 16x16 instance plus a 12-column
// instance, both backed by a behavioural 1-cycle-latency occupancy memory.
module tb_food_spawner;

  logic       clk;
  logic       reset_n;
  logic       req, req_12;
  logic [8:0] rnd, rnd_12;
  logic       occ_rd_en, occ_rd_en_12;
  logic [3:0] occ_rd_x, occ_rd_x_12;
  logic [3:0] occ_rd_y, occ_rd_y_12;
  logic       occ_rd_data, occ_rd_data_12;
  logic       busy, busy_12;
  logic       done, done_12;
  logic       board_full, board_full_12;
  logic [3:0] food_x, food_x_12;
  logic [3:0] food_y, food_y_12;

  int total = 0;
  int bad   = 0;
  int consec = 0;

  logic occ_mem [256];

  food_spawner u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .rnd        (rnd),
    .occ_rd_en  (occ_rd_en),
    .occ_rd_x   (occ_rd_x),
    .occ_rd_y   (occ_rd_y),
    .occ_rd_data(occ_rd_data),
    .busy       (busy),
    .done       (done),
    .board_full (board_full),
    .food_x     (food_x),
    .food_y     (food_y)
  );

  food_spawner #(.GRID_W(12)) u_dut_12 (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req_12),
    .rnd        (rnd_12),
    .occ_rd_en  (occ_rd_en_12),
    .occ_rd_x   (occ_rd_x_12),
    .occ_rd_y   (occ_rd_y_12),
    .occ_rd_data(occ_rd_data_12),
    .busy       (busy_12),
    .done       (done_12),
    .board_full (board_full_12),
    .food_x     (food_x_12),
    .food_y     (food_y_12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Occupancy memory with registered read data.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_rd_data    <= 1'b0;
      occ_rd_data_12 <= 1'b0;
    end else begin
      if (occ_rd_en)    occ_rd_data    <= occ_mem[{occ_rd_y, occ_rd_x}];
      if (occ_rd_en_12) occ_rd_data_12 <= occ_mem[{occ_rd_y_12, occ_rd_x_12}];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic v);
    for (int i = 0; i < 256; i++) occ_mem[i] = v;
  endtask

  // Pulse req on the 16x16 instance and follow it to done (bounded).
  // Returns done cycle (-1 on timeout), read count, and address/cycle of read number pidx.
  task automatic spawn(input logic [8:0] r, input int max_cyc, input int pidx,
                       output int cyc, output int reads,
                       output logic [7:0] paddr, output int pcyc);
    logic prev;
    rnd   = r;
    req   = 1'b1;
    cyc   = -1;
    reads = 0;
    paddr = 8'h00;
    pcyc  = -1;
    prev  = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      tick();
      if (c == 1) req = 1'b0;
      if (occ_rd_en) begin
        if (reads == pidx) begin
          paddr = {occ_rd_y, occ_rd_x};
          pcyc  = c;
        end
        if (prev) consec++;
        reads++;
      end
      prev = occ_rd_en;
      if (done) begin
        cyc = c;
        break;
      end
    end
  endtask

  int         cyc, reads, pcyc, ndone, d1, d2;
  logic [7:0] paddr;

  initial begin
    reset_n = 1'b0;
    req = 1'b0; rnd = '0; req_12 = 1'b0; rnd_12 = '0;
    set_all(1'b0);
    #12;
    // Reset values
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_en", 32'(occ_rd_en), 0);
    chk("rst_food", {24'h0, food_y, food_x}, 0);
    reset_n = 1'b1;
    tick();

    // All free, first-try success
    spawn(9'h0A5, 10, 0, cyc, reads, paddr, pcyc);
    chk("t2_done_cyc", 32'(cyc), 3);
    chk("t2_rd_cyc", 32'(pcyc), 1);
    chk("t2_rd_addr", 32'(paddr), 32'h0A5);
    chk("t2_reads", 32'(reads), 1);
    chk("t2_food_x", 32'(food_x), 5);
    chk("t2_food_y", 32'(food_y), 10);
    chk("t2_full", 32'(board_full), 0);
    chk("t2_busy", 32'(busy), 0);
    tick();
    chk("t2_done_pulse", 32'(done), 0);

    // 12-column grid: x=13 out of range for three cycles
    rnd_12 = 9'h00D;
    req_12 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      req_12 = 1'b0;
      chk("t3_no_read", 32'(occ_rd_en_12), 0);
      chk("t3_busy", 32'(busy_12), 1);
    end
    tick();
    rnd_12 = 9'h034;
    #1;
    chk("t3_rd_en", 32'(occ_rd_en_12), 1);
    chk("t3_rd_addr", {24'h0, occ_rd_y_12, occ_rd_x_12}, 32'h34);
    tick();
    tick();
    chk("t3_done", 32'(done_12), 1);
    chk("t3_food", {24'h0, food_y_12, food_x_12}, 32'h34);
    chk("t3_full", 32'(board_full_12), 0);
    tick();

    // req toggled while busy: one done only
    rnd = 9'h0A5;
    req = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      req = (c == 2);
      if (done) ndone++;
    end
    chk("t6_one_done", 32'(ndone), 1);

    // req held high: back-to-back spawns 3 cycles apart
    req = 1'b1;
    ndone = 0; d1 = -1; d2 = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (done) begin
        if (ndone == 0) d1 = c;
        else if (ndone == 1) d2 = c;
        ndone++;
      end
    end
    req = 1'b0;
    chk("t6_ndone", 32'(ndone), 3);
    chk("t6_first", 32'(d1), 3);
    chk("t6_gap", 32'(d2 - d1), 3);
    for (int c = 0; c < 5; c++) tick();
    chk("t6_idle", 32'(busy), 0);

    // Only (3,3) free: 32 rejections of (2,1) then scan from (3,1)
    set_all(1'b1);
    occ_mem[8'h33] = 1'b0;
    spawn(9'h012, 700, 32, cyc, reads, paddr, pcyc);
    chk("t4_done_cyc", 32'(cyc), 131);
    chk("t4_reads", 32'(reads), 65);
    chk("t4_scan_start", 32'(paddr), 32'h13);
    chk("t4_food", {24'h0, food_y, food_x}, 32'h33);
    chk("t4_full", 32'(board_full), 0);
    tick();

    // All occupied: board_full, food held
    set_all(1'b1);
    spawn(9'h012, 700, 32, cyc, reads, paddr, pcyc);
    chk("t5_done_cyc", 32'(cyc), 577);
    chk("t5_reads", 32'(reads), 288);
    chk("t5_full", 32'(board_full), 1);
    chk("t5_food", {24'h0, food_y, food_x}, 32'h33);
    tick();
    chk("t5_full_clr", 32'(board_full), 0);

    // Reset mid-scan
    rnd = 9'h012;
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int c = 0; c < 100; c++) tick();
    chk("t1_busy_pre", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("t1_busy", 32'(busy), 0);
    chk("t1_done", 32'(done), 0);
    chk("t1_full", 32'(board_full), 0);
    chk("t1_rd", {27'h0, occ_rd_en, occ_rd_y}, 0);
    chk("t1_rd_x", 32'(occ_rd_x), 0);
    chk("t1_food", {24'h0, food_y, food_x}, 0);
    #2;
    reset_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("t1_no_done", 32'(ndone), 0);

    chk("no_b2b_rd", 32'(consec), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
